// File: rtl/hazard_scoreboard_pkg.sv
// hazard_scoreboard_pkg: shared MIPS register constants and hazard helper for the scoreboard
package hazard_scoreboard_pkg;
   localparam int NUM_REGS = 32;
   localparam logic [4:0] REG_ZERO = 5'd0;
   localparam logic [4:0] REG_RA = 5'd31;
   function automatic logic src_hazard(input logic used, input logic nonzero, input logic raw,
                                       input logic bypass);
      return used & nonzero & raw & ~bypass;
   endfunction
endpackage

// File: rtl/hazard_scoreboard_counter.sv
// scoreboard_counter: per-register in-flight writer count with one increment, two decrements, floor at zero
module scoreboard_counter #(
   parameter int CNT_BITS = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                inc,
   input  logic [1:0]          dec,
   output logic [CNT_BITS-1:0] count,
   output logic                full
);
   localparam int W = CNT_BITS + 2;
   logic [W-1:0] nxt;
   assign full = &count;
   // Two spare bits: the top one flags an underflow, the next one an (unreachable) overflow.
   assign nxt = W'(count) + W'(inc & ~full) - W'(dec[0]) - W'(dec[1]);
   always_ff @(posedge clk) begin
      count <= (rst | nxt[W-1]) ? '0 : nxt[W-2] ? '1 : nxt[CNT_BITS-1:0];
   end
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: RAW / writer-saturation stall logic; define HAZARD_FORWARD_EN for load-use-only hazards
module hazard_scoreboard
   import hazard_scoreboard_pkg::*;
#(
   parameter int BITS_REGS = 5,
   parameter int CNT_BITS = 2,
   parameter int STALL_CNT_BITS = 16
) (
   input  logic                      i_clk,
   input  logic                      i_reset,
   input  logic                      i_issue_valid,
   input  logic                      i_issue_writes,
   input  logic                      i_issue_jal,
   input  logic                      i_issue_load,
   input  logic [BITS_REGS-1:0]      i_issue_rd,
   input  logic [BITS_REGS-1:0]      i_rs,
   input  logic [BITS_REGS-1:0]      i_rt,
   input  logic                      i_rs_used,
   input  logic                      i_rt_used,
   input  logic                      i_wb_valid,
   input  logic [BITS_REGS-1:0]      i_wb_rd,
   input  logic                      i_kill_valid,
   input  logic [BITS_REGS-1:0]      i_kill_rd,
   output logic                      o_stall,
   output logic [31:0]               o_busy_mask,
   output logic [STALL_CNT_BITS-1:0] o_stall_cycles
);
   logic [NUM_REGS-1:0][CNT_BITS-1:0] counts;
   logic [NUM_REGS-1:0] full, busy;
   logic [BITS_REGS-1:0] eff_rd, load_rd;
   logic [STALL_CNT_BITS-1:0] stall_cycles;
   logic accept, stall, load_valid, raw_rs, raw_rt, byp_rs, byp_rt;

   assign eff_rd = i_issue_jal ? BITS_REGS'(REG_RA) : i_issue_rd;
   assign accept = i_issue_valid & ~stall;
   assign counts[0] = '0;
   assign full[0] = 1'b0;

   for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
      scoreboard_counter #(.CNT_BITS(CNT_BITS)) u_cnt (
         .clk(i_clk),
         .rst(i_reset),
         .inc(accept & i_issue_writes & (eff_rd == BITS_REGS'(r))),
         .dec({i_kill_valid & (i_kill_rd == BITS_REGS'(r)), i_wb_valid & (i_wb_rd == BITS_REGS'(r))}),
         .count(counts[r]),
         .full(full[r])
      );
   end

   always_comb begin
      busy = '0;
      for (int n = 1; n < NUM_REGS; n++) busy[n] = |counts[n];
   end

   // A last in-flight writer retiring this very cycle is forwarded, not waited on.
   assign byp_rs = (counts[i_rs] == CNT_BITS'(1)) & i_wb_valid & (i_wb_rd == i_rs);
   assign byp_rt = (counts[i_rt] == CNT_BITS'(1)) & i_wb_valid & (i_wb_rd == i_rt);
`ifdef HAZARD_FORWARD_EN
   assign raw_rs = load_valid & (i_rs == load_rd);
   assign raw_rt = load_valid & (i_rt == load_rd);
`else
   logic unused_load;
   assign unused_load = ^{load_rd, load_valid};
   assign raw_rs = |counts[i_rs];
   assign raw_rt = |counts[i_rt];
`endif

   assign stall = i_issue_valid & ~i_reset & (full[eff_rd]
                  | src_hazard(i_rs_used, |i_rs, raw_rs, byp_rs)
                  | src_hazard(i_rt_used, |i_rt, raw_rt, byp_rt));

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         load_valid <= 1'b0;
         load_rd <= '0;
         stall_cycles <= '0;
      end else begin
         load_valid <= accept & i_issue_load & i_issue_writes & ~(i_kill_valid & (i_kill_rd == eff_rd));
         load_rd <= eff_rd;
         stall_cycles <= (stall & ~&stall_cycles) ? stall_cycles + 1'b1 : stall_cycles;
      end
   end

   assign o_stall = stall;
   assign o_busy_mask = i_reset ? '0 : busy;
   assign o_stall_cycles = i_reset ? '0 : stall_cycles;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed scenarios for hazard_scoreboard in either HAZARD_FORWARD_EN build
module tb_hazard_scoreboard;
   import hazard_scoreboard_pkg::*;
`ifdef HAZARD_FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif
   logic clk = 0, reset = 1;
   logic issue_valid, issue_writes, issue_jal, issue_load, rs_used, rt_used, wb_valid, kill_valid;
   logic [4:0] issue_rd, rs, rt, wb_rd, kill_rd;
   logic stall;
   logic [31:0] busy_mask;
   logic [15:0] stall_cycles;
   int checks = 0, errors = 0;

   hazard_scoreboard dut (
      .i_clk(clk), .i_reset(reset), .i_issue_valid(issue_valid), .i_issue_writes(issue_writes),
      .i_issue_jal(issue_jal), .i_issue_load(issue_load), .i_issue_rd(issue_rd), .i_rs(rs), .i_rt(rt),
      .i_rs_used(rs_used), .i_rt_used(rt_used), .i_wb_valid(wb_valid), .i_wb_rd(wb_rd),
      .i_kill_valid(kill_valid), .i_kill_rd(kill_rd), .o_stall(stall), .o_busy_mask(busy_mask),
      .o_stall_cycles(stall_cycles)
   );

   always #5 clk = ~clk;

   task automatic idle();
      {issue_valid, issue_writes, issue_jal, issue_load, rs_used, rt_used, wb_valid, kill_valid} = '0;
      {issue_rd, rs, rt, wb_rd, kill_rd} = '0;
   endtask

   task automatic issue_wr(input logic [4:0] rd, input logic load);
      idle();
      issue_valid = 1; issue_writes = 1; issue_rd = rd; issue_load = load;
   endtask

   task automatic test_reset();
      idle();
      reset = 1;
      repeat (2) @(negedge clk);
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
      checks++; if (busy_mask !== 32'h0) begin errors++; $display("FAIL reset_mask: got %h want 0", busy_mask); end
      checks++; if (stall_cycles !== 16'h0) begin errors++; $display("FAIL reset_cycles: got %0d want 0", stall_cycles); end
      reset = 0;
   endtask

   task automatic test_raw();
      @(negedge clk); issue_wr(5'd5, 0); #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL raw_issue: got %b want 0", stall); end
      @(negedge clk); idle(); issue_valid = 1; rs = 5'd5; rs_used = 0; #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL raw_unused_src: got %b want 0", stall); end
      rs_used = 1; #1;
      checks++; if (stall !== !FWD) begin errors++; $display("FAIL raw_stall: got %b want %b", stall, !FWD); end
      checks++; if (busy_mask !== 32'h20) begin errors++; $display("FAIL raw_mask: got %h want 00000020", busy_mask); end
      @(negedge clk); #1;
      checks++; if (stall !== !FWD) begin errors++; $display("FAIL raw_hold: got %b want %b", stall, !FWD); end
      idle(); issue_valid = 1; rs = 5'd5; rs_used = 1; wb_valid = 1; wb_rd = 5'd5; #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL raw_wb_bypass: got %b want 0", stall); end
      @(negedge clk); idle(); #1;
      checks++; if (busy_mask !== 32'h0) begin errors++; $display("FAIL raw_after_wb: got %h want 0", busy_mask); end
   endtask

   task automatic test_load_use();
      @(negedge clk); issue_wr(5'd8, 1);
      @(negedge clk); idle(); issue_valid = 1; rt = 5'd8; rt_used = 1; #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL load_use_1: got %b want 1", stall); end
      @(negedge clk); #1;
      checks++; if (stall !== !FWD) begin errors++; $display("FAIL load_use_2: got %b want %b", stall, !FWD); end
      @(negedge clk); idle(); wb_valid = 1; wb_rd = 5'd8;
      @(negedge clk); idle(); #1;
      checks++; if (busy_mask !== 32'h0) begin errors++; $display("FAIL load_clean: got %h want 0", busy_mask); end
      issue_wr(5'd8, 0);
      @(negedge clk); idle(); issue_valid = 1; rt = 5'd8; rt_used = 1; #1;
      checks++; if (stall !== !FWD) begin errors++; $display("FAIL alu_use: got %b want %b", stall, !FWD); end
      @(negedge clk); idle(); wb_valid = 1; wb_rd = 5'd8;
      @(negedge clk); idle();
   endtask

   task automatic test_jal();
      @(negedge clk); issue_wr(5'd3, 0); issue_jal = 1;
      @(negedge clk); idle(); #1;
      checks++; if (busy_mask !== 32'h8000_0000) begin errors++; $display("FAIL jal_mask: got %h want 80000000", busy_mask); end
      wb_valid = 1; wb_rd = REG_RA;
      @(negedge clk); issue_wr(REG_ZERO, 0);
      @(negedge clk); idle(); #1;
      checks++; if (busy_mask !== 32'h0) begin errors++; $display("FAIL zero_mask: got %h want 0", busy_mask); end
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); issue_wr(5'd7, 0); #1;
         checks++; if (stall !== 1'b0) begin errors++; $display("FAIL sat_fill%0d: got %b want 0", i, stall); end
      end
      @(negedge clk); #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sat_full: got %b want 1", stall); end
      checks++; if (busy_mask !== 32'h80) begin errors++; $display("FAIL sat_mask: got %h want 00000080", busy_mask); end
      wb_valid = 1; wb_rd = 5'd7; #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sat_wb_same: got %b want 1", stall); end
      @(negedge clk); wb_valid = 0; #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL sat_accept: got %b want 0", stall); end
      @(negedge clk); #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sat_refull: got %b want 1", stall); end
      idle(); wb_valid = 1; wb_rd = 5'd7;
      repeat (3) @(negedge clk);
      idle(); #1;
      checks++; if (busy_mask !== 32'h0) begin errors++; $display("FAIL sat_drain: got %h want 0", busy_mask); end
   endtask

   task automatic test_kill();
      @(negedge clk); issue_wr(5'd9, 0);
      @(negedge clk); issue_wr(5'd9, 0); kill_valid = 1; kill_rd = 5'd9; #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL kill_issue: got %b want 0", stall); end
      @(negedge clk); idle(); #1;
      checks++; if (busy_mask !== 32'h200) begin errors++; $display("FAIL kill_same_edge: got %h want 00000200", busy_mask); end
      kill_valid = 1; kill_rd = 5'd9;
      @(negedge clk); #1;
      checks++; if (busy_mask !== 32'h0) begin errors++; $display("FAIL kill_to_zero: got %h want 0", busy_mask); end
      @(negedge clk); issue_wr(5'd9, 0); #1;
      checks++; if (busy_mask !== 32'h0) begin errors++; $display("FAIL kill_at_zero: got %h want 0", busy_mask); end
      @(negedge clk); idle(); wb_valid = 1; wb_rd = 5'd9;
      @(negedge clk); idle(); #1;
      checks++; if (busy_mask !== 32'h0) begin errors++; $display("FAIL kill_no_underflow: got %h want 0", busy_mask); end
   endtask

   task automatic test_reset_mid();
      @(negedge clk); idle(); reset = 1;
      @(negedge clk); reset = 0;
      repeat (3) begin @(negedge clk); issue_wr(5'd7, 0); end
      @(negedge clk); issue_wr(5'd4, 0);
      repeat (10) begin @(negedge clk); issue_wr(5'd7, 0); end
      @(negedge clk); idle(); #1;
      checks++; if (stall_cycles !== 16'd10) begin errors++; $display("FAIL mid_cycles: got %0d want 10", stall_cycles); end
      checks++; if (busy_mask !== 32'h90) begin errors++; $display("FAIL mid_mask: got %h want 00000090", busy_mask); end
      reset = 1; issue_wr(5'd7, 0); wb_valid = 1; wb_rd = 5'd4; #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL in_reset_stall: got %b want 0", stall); end
      checks++; if (busy_mask !== 32'h0) begin errors++; $display("FAIL in_reset_mask: got %h want 0", busy_mask); end
      @(negedge clk); reset = 0; idle(); #1;
      checks++; if (busy_mask !== 32'h0) begin errors++; $display("FAIL post_reset_mask: got %h want 0", busy_mask); end
      checks++; if (stall_cycles !== 16'h0) begin errors++; $display("FAIL post_reset_cycles: got %0d want 0", stall_cycles); end
      issue_wr(5'd7, 0); #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL post_reset_issue: got %b want 0", stall); end
      @(negedge clk); idle();
   endtask

   initial begin
      idle();
      test_reset();
      test_raw();
      test_load_use();
      test_jal();
      test_saturation();
      test_kill();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
